// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the step-sequencer audio engine.
//   - HP_W_DEF : default half-period width in synth ticks
//   - NOTE_*   : half-period constants (synth ticks) for B1..A3, computed for
//                a 12 MHz clk with SYNTH_DIV = 10 (synth rate ~11.72 kHz),
//                hp = round(synth_rate / (2 * f_note))
//   - popcount : number of set bits in an up-to-8-bit voice mask
package audio_pkg;

    localparam int HP_W_DEF = 7;

    localparam logic [HP_W_DEF-1:0] NOTE_B1 = 7'd95;
    localparam logic [HP_W_DEF-1:0] NOTE_C2 = 7'd90;
    localparam logic [HP_W_DEF-1:0] NOTE_D2 = 7'd80;
    localparam logic [HP_W_DEF-1:0] NOTE_E2 = 7'd71;
    localparam logic [HP_W_DEF-1:0] NOTE_F2 = 7'd67;
    localparam logic [HP_W_DEF-1:0] NOTE_G2 = 7'd60;
    localparam logic [HP_W_DEF-1:0] NOTE_A2 = 7'd53;
    localparam logic [HP_W_DEF-1:0] NOTE_B2 = 7'd47;
    localparam logic [HP_W_DEF-1:0] NOTE_C3 = 7'd45;
    localparam logic [HP_W_DEF-1:0] NOTE_D3 = 7'd40;
    localparam logic [HP_W_DEF-1:0] NOTE_E3 = 7'd36;
    localparam logic [HP_W_DEF-1:0] NOTE_F3 = 7'd34;
    localparam logic [HP_W_DEF-1:0] NOTE_G3 = 7'd30;
    localparam logic [HP_W_DEF-1:0] NOTE_A3 = 7'd27;

    // Voice masks narrower than 8 bits are zero-extended by the caller.
    function automatic logic [3:0] popcount(input logic [7:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave tone generator.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   synth_tick  : one-cycle strobe at the synth rate
//   active      : voice is gated on, unmuted and has a non-zero half-period
//   hp          : half-period in synth ticks (only meaningful while active)
//   sq          : registered square output
// While inactive the voice is held silent with its phase cleared, so every
// note starts from a known phase when the gate opens.
module tone_voice
    import audio_pkg::*;
#(
    parameter int HP_W = HP_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            synth_tick,
    input  logic            active,
    input  logic [HP_W-1:0] hp,
    output logic            sq
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (!active) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (synth_tick) begin
            // >= rather than == so that lowering hp mid-period cannot leave
            // cnt above the new terminal value.
            if (cnt >= hp - HP_W'(1)) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/poly_audio_engine.sv
// poly_audio_engine: multi-voice step sequencer with a 1-bit PWM mix.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   enable      : run (1) / pause (0); pause freezes the step position
//   loop_last   : last step index before wrapping to 0
//   mute        : per-voice mute mask
//   hp_in       : per-voice half-period from an external combinational LUT
//                 addressed by step_idx; voice v at [v*HP_W +: HP_W]
//   step_idx    : current step (registered)
//   step_start  : one-cycle pulse in the cycle step_idx takes a new value
//   voice_sq    : per-voice square bits (registered)
//   audio       : PWM mix of the voices (registered)
// All timing derives from clk through strobes; there are no derived clocks.
module poly_audio_engine
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int HP_W       = HP_W_DEF,
    parameter int STEP_W     = 7,
    parameter int SYNTH_DIV  = 10,
    parameter int SEQ_DIV    = 17,
    parameter int STEP_TICKS = 20,
    parameter int GATE_TICKS = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [STEP_W-1:0]          loop_last,
    input  logic [NUM_VOICES-1:0]      mute,
    input  logic [NUM_VOICES*HP_W-1:0] hp_in,
    output logic [STEP_W-1:0]          step_idx,
    output logic                       step_start,
    output logic [NUM_VOICES-1:0]      voice_sq,
    output logic                       audio
);

    localparam int PRE_W  = (SYNTH_DIV > SEQ_DIV) ? SYNTH_DIV : SEQ_DIV;
    localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int SUM_W  = $clog2(NUM_VOICES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
    // One extra bit so GATE_TICKS == 2^TICK_W still compares correctly.
    localparam logic [TICK_W:0]   GATE_LIM  = (TICK_W + 1)'(GATE_TICKS);
    localparam logic [SUM_W-1:0]  PWM_LAST  = SUM_W'(NUM_VOICES - 1);

    logic [PRE_W-1:0]      pre_ctr;
    logic                  synth_tick;
    logic                  seq_tick;
    logic [TICK_W-1:0]     tick_ctr;
    logic                  gate;
    logic                  init_q;
    logic [HP_W-1:0]       hp_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] hp_nz;
    logic [NUM_VOICES-1:0] voice_active;
    wire  [NUM_VOICES-1:0] sq_w;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      pwm_ctr;

    // Free-running prescaler; keeps counting while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_ctr <= '0;
        else        pre_ctr <= pre_ctr + PRE_W'(1);
    end

    assign synth_tick = &pre_ctr[SYNTH_DIV-1:0];
    assign seq_tick   = &pre_ctr[SEQ_DIV-1:0];

    // Step control. A seq_tick that coincides with enable low is dropped.
    // The >= wrap test lets a lowered loop_last take effect on the next step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_ctr   <= '0;
            step_idx   <= '0;
            step_start <= 1'b0;
        end else begin
            step_start <= 1'b0;
            if (enable && seq_tick) begin
                if (tick_ctr == TICK_LAST) begin
                    tick_ctr   <= '0;
                    step_idx   <= (step_idx >= loop_last) ? '0 : step_idx + STEP_W'(1);
                    step_start <= 1'b1;
                end else begin
                    tick_ctr <= tick_ctr + TICK_W'(1);
                end
            end
        end
    end

    assign gate = enable & ({1'b0, tick_ctr} < GATE_LIM);

    // hp_in follows step_idx combinationally, so it is sampled while
    // step_start is high; init_q covers step 0 right after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 1'b1;
        else        init_q <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) hp_q[v] <= '0;
        end else if (step_start || init_q) begin
            for (int v = 0; v < NUM_VOICES; v++) hp_q[v] <= hp_in[v*HP_W +: HP_W];
        end
    end

    always_comb begin
        hp_nz = '0;
        for (int v = 0; v < NUM_VOICES; v++) hp_nz[v] = (hp_q[v] != '0);
    end

    assign voice_active = {NUM_VOICES{gate}} & ~mute & hp_nz;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .HP_W(HP_W)
        ) u_voice (
            .clk       (clk),
            .rst_n     (rst_n),
            .synth_tick(synth_tick),
            .active    (voice_active[v]),
            .hp        (hp_q[v]),
            .sq        (sq_w[v])
        );
    end

    assign voice_sq = sq_w;

    // PWM mixer: over each NUM_VOICES-cycle frame audio is high for as many
    // cycles as there are voices currently high.
    assign sum = SUM_W'(popcount(8'(voice_sq)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_ctr <= '0;
            audio   <= 1'b0;
        end else begin
            pwm_ctr <= (pwm_ctr == PWM_LAST) ? '0 : pwm_ctr + SUM_W'(1);
            audio   <= (pwm_ctr < sum);
        end
    end

endmodule

// File: tb/tb_poly_audio_engine.sv
// Self-checking bench for poly_audio_engine with small dividers so that a
// step lasts 64 clk (4 seq ticks of 16 clk) and synth ticks every 4 clk.
module tb_poly_audio_engine;

    localparam int NV = 2;
    localparam int HPW = 7;
    localparam int SW = 7;
    localparam int SYN = 4;     // clk per synth tick
    localparam int SEQ = 16;    // clk per seq tick
    localparam int ST = 4;      // seq ticks per step
    localparam int GT = 2;      // seq ticks with gate open
    localparam int VW = SW + NV + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic [SW-1:0] loop_last = '0;
    logic [NV-1:0] mute = '0;
    logic [NV*HPW-1:0] hp_in;
    logic [SW-1:0] step_idx;
    logic step_start;
    logic [NV-1:0] voice_sq;
    logic audio;

    logic [HPW-1:0] lut [NV][128];
    int n_cmp = 0;
    int n_fail = 0;

    poly_audio_engine #(
        .NUM_VOICES(NV), .HP_W(HPW), .STEP_W(SW), .SYNTH_DIV(2),
        .SEQ_DIV(4), .STEP_TICKS(ST), .GATE_TICKS(GT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .loop_last(loop_last),
        .mute(mute), .hp_in(hp_in), .step_idx(step_idx),
        .step_start(step_start), .voice_sq(voice_sq), .audio(audio)
    );

    always #5 clk = ~clk;

    // Pattern LUT, addressed by the DUT's own step index.
    always_comb begin
        hp_in = '0;
        for (int v = 0; v < NV; v++) hp_in[v*HPW +: HPW] = lut[v][step_idx];
    end

    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;
    assign obs_vec = {step_idx, step_start, voice_sq, audio};

    // Reference model. Time is counted in clk since reset release (m_cyc);
    // a voice's square level is (synth ticks since it became active / hp) mod 2.
    int m_cyc, m_tick, m_step, m_popc, m_start_new;
    logic m_start, m_init, m_audio, m_gate, m_act, m_synth, m_seq;
    int m_hpq [NV];
    int m_n [NV];
    logic [NV-1:0] m_sq;

    initial begin
        m_cyc = 0; m_tick = 0; m_step = 0; m_start = 1'b0; m_init = 1'b1;
        m_audio = 1'b0; m_sq = '0; exp_vec = '0;
        for (int v = 0; v < NV; v++) begin m_hpq[v] = 0; m_n[v] = 0; end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cyc = 0; m_tick = 0; m_step = 0; m_start = 1'b0; m_init = 1'b1;
                m_audio = 1'b0; m_sq = '0;
                for (int v = 0; v < NV; v++) begin m_hpq[v] = 0; m_n[v] = 0; end
            end else begin
                m_synth = ((m_cyc % SYN) == SYN - 1);
                m_seq = ((m_cyc % SEQ) == SEQ - 1);
                m_gate = enable && (m_tick < GT);
                m_popc = 0;
                for (int v = 0; v < NV; v++) m_popc += int'(m_sq[v]);
                m_audio = ((m_cyc % NV) < m_popc);
                for (int v = 0; v < NV; v++) begin
                    m_act = m_gate && !mute[v] && (m_hpq[v] != 0);
                    if (!m_act) begin
                        m_n[v] = 0;
                        m_sq[v] = 1'b0;
                    end else if (m_synth) begin
                        m_n[v]++;
                        m_sq[v] = ((m_n[v] / m_hpq[v]) % 2) == 1;
                    end
                end
                if (m_start || m_init) begin
                    for (int v = 0; v < NV; v++) m_hpq[v] = int'(lut[v][m_step]);
                end
                m_init = 1'b0;
                m_start_new = 0;
                if (enable && m_seq) begin
                    if (m_tick == ST - 1) begin
                        m_tick = 0;
                        m_step = (m_step >= int'(loop_last)) ? 0 : m_step + 1;
                        m_start_new = 1;
                    end else begin
                        m_tick++;
                    end
                end
                m_start = (m_start_new == 1);
                m_cyc++;
            end
            exp_vec = {m_step[SW-1:0], m_start, m_sq, m_audio};
        end
    end

    task automatic fill_lut(input int h0, input int h1);
        for (int s = 0; s < 128; s++) begin
            lut[0][s] = HPW'(h0);
            lut[1][s] = HPW'(h1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; loop_last = SW'(3); mute = '0;
        fill_lut(5, 5);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (step_idx !== '0) begin n_fail++; $display("FAIL reset_step_idx got %h exp 0", step_idx); end
        n_cmp++; if (step_start !== 1'b0) begin n_fail++; $display("FAIL reset_step_start got %b exp 0", step_start); end
        n_cmp++; if (voice_sq !== '0) begin n_fail++; $display("FAIL reset_voice_sq got %b exp 0", voice_sq); end
        n_cmp++; if (audio !== 1'b0) begin n_fail++; $display("FAIL reset_audio got %b exp 0", audio); end
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Must be called directly after test_reset: cycle c is edge c after release.
    task automatic test_step_seq();
        int last, k;
        last = 0; k = 0;
        for (int c = 1; c <= 320; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL step_seq_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
            if (step_start) begin
                k++;
                n_cmp++; if (c - last != 64) begin n_fail++; $display("FAIL step_seq_interval got %0d exp 64", c - last); end
                n_cmp++; if (step_idx !== SW'(k % 4)) begin n_fail++; $display("FAIL step_seq_idx got %0d exp %0d", step_idx, k % 4); end
                last = c;
            end
        end
        n_cmp++; if (k != 5) begin n_fail++; $display("FAIL step_seq_count got %0d exp 5", k); end
    endtask

    task automatic test_tone();
        bit found, prev0;
        int rise, rises, sq_hi, au_hi;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; if (step_start) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL tone_sync got timeout exp step_start"); end
        fill_lut(3, 0);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; if (step_start) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL tone_sync2 got timeout exp step_start"); end
        prev0 = voice_sq[0]; rise = 0; rises = 0; sq_hi = 0; au_hi = 0;
        for (int c = 1; c <= 256; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL tone_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
            if (prev0) sq_hi++;
            if (prev0 && audio) au_hi++;
            if (voice_sq[0] && !prev0) begin rise = c; rises++; end
            if (!voice_sq[0] && prev0) begin
                n_cmp++; if (c - rise != 12) begin n_fail++; $display("FAIL tone_half_period got %0d exp 12", c - rise); end
            end
            n_cmp++; if (voice_sq[1] !== 1'b0) begin n_fail++; $display("FAIL tone_rest_voice got %b exp 0", voice_sq[1]); end
            prev0 = voice_sq[0];
        end
        n_cmp++; if (rises != 4) begin n_fail++; $display("FAIL tone_rises got %0d exp 4", rises); end
        n_cmp++; if (sq_hi != 48 || au_hi * 2 != sq_hi) begin n_fail++; $display("FAIL tone_duty got sq_hi=%0d au_hi=%0d exp 48/24", sq_hi, au_hi); end
    endtask

    task automatic test_mix_mute();
        bit found, prev_both;
        int both;
        fill_lut(1, 1);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; if (step_start) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL mix_sync got timeout exp step_start"); end
        prev_both = (voice_sq == 2'b11); both = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL mix_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
            if (prev_both) begin
                both++;
                n_cmp++; if (audio !== 1'b1) begin n_fail++; $display("FAIL mix_full got %b exp 1", audio); end
            end
            prev_both = (voice_sq == 2'b11);
        end
        n_cmp++; if (both == 0) begin n_fail++; $display("FAIL mix_in_phase got 0 cycles exp >0"); end
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; if (voice_sq[0]) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL mute_sync got timeout exp voice_sq[0]=1"); end
        mute = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (voice_sq[0] !== 1'b0) begin n_fail++; $display("FAIL mute_voice0 got %b exp 0", voice_sq[0]); end
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL mute_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
        end
        mute = 2'b00;
    endtask

    task automatic test_loop_wrap();
        bit found;
        loop_last = SW'(7);
        found = 0;
        for (int c = 0; c < 700 && !found; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrap_vec got %h exp %h", obs_vec, exp_vec); end
            if (step_idx == SW'(5)) found = 1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL wrap_reach5 got timeout exp step_idx=5"); end
        loop_last = SW'(2);
        found = 0;
        for (int c = 0; c < 80 && !found; c++) begin @(posedge clk); #1; if (step_start) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL wrap_next got timeout exp step_start"); end
        n_cmp++; if (step_idx !== '0) begin n_fail++; $display("FAIL wrap_forced got %0d exp 0", step_idx); end
    endtask

    task automatic test_pause();
        bit found;
        int starts;
        logic [SW-1:0] held;
        fill_lut(2, 3);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; if (step_start) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL pause_sync got timeout exp step_start"); end
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        held = step_idx;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (audio !== 1'b0 || voice_sq !== '0) begin n_fail++; $display("FAIL pause_silence got audio=%b sq=%b exp 0/00", audio, voice_sq); end
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (step_idx !== held || step_start !== 1'b0) begin n_fail++; $display("FAIL pause_hold got %0d/%b exp %0d/0", step_idx, step_start, held); end
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL pause_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
        end
        enable = 1'b1;
        starts = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (step_start) starts++;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL resume_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
        end
        n_cmp++; if (starts == 0) begin n_fail++; $display("FAIL resume_steps got 0 exp >0"); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < 128; s++) begin
                lut[0][s] = HPW'($urandom_range(0, 7));
                lut[1][s] = HPW'($urandom_range(0, 7));
            end
            mute = NV'($urandom_range(0, 3));
            loop_last = SW'($urandom_range(0, 7));
            for (int c = 1; c <= 300; c++) begin
                @(posedge clk); #1;
                n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_vec it=%0d c=%0d got %h exp %h", it, c, obs_vec, exp_vec); end
            end
        end
        mute = '0;
    endtask

    task automatic test_reset_mid();
        bit found;
        fill_lut(2, 3);
        loop_last = SW'(3);
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin @(posedge clk); #1; if (voice_sq != '0 && step_idx != '0) found = 1; end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rst_mid_sync got timeout exp tone"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (obs_vec !== '0) begin n_fail++; $display("FAIL rst_mid_immediate got %h exp 0", obs_vec); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rst_mid_vec c=%0d got %h exp %h", c, obs_vec, exp_vec); end
            if (c == 1) begin
                n_cmp++; if (step_idx !== '0) begin n_fail++; $display("FAIL rst_mid_step0 got %0d exp 0", step_idx); end
            end
            if (step_start && !found) begin
                found = 1;
                n_cmp++; if (c != 64) begin n_fail++; $display("FAIL rst_mid_first_step got %0d exp 64", c); end
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rst_mid_replay got timeout exp step_start"); end
    endtask

    initial begin
        test_reset();
        test_step_seq();
        test_tone();
        test_mix_mute();
        test_loop_wrap();
        test_pause();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
